alu_muldiv: RTL and testbench

Iterative multiply/divide unit that sits beside the single-cycle ALU in the SPARC datapath and executes the UMUL/SMUL/UDIV/SDIV family (plain and `cc` forms), which the combinational ALU cannot do. The operand width is set by a parameter. The unit computes radix-2, one bit per cycle. It uses a start/busy/done handshake, returns the product high half or the remainder on `y_out`, and keeps its own registered icc flags.

---
 rtl/alu_muldiv_if.sv | 30 +++
 rtl/alu_muldiv.sv | 172 +++++++++++++++++
 tb/tb_alu_muldiv.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/alu_muldiv_if.sv
// Request/response bundle for the iterative multiply/divide unit.
// The requester drives the master side; alu_muldiv sits on the slave side.
interface alu_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [5:0]       op3;
  logic [WIDTH-1:0] ain;
  logic [WIDTH-1:0] bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] y_out;
  logic             n;
  logic             z;
  logic             v;
  logic             c;
  logic             div_zero;
  logic             illegal;

  modport master (
    output start, op3, ain, bin,
    input  busy, done, out, y_out, n, z, v, c, div_zero, illegal
  );

  modport slave (
    input  start, op3, ain, bin,
    output busy, done, out, y_out, n, z, v, c, div_zero, illegal
  );
endinterface

// File: rtl/alu_muldiv.sv
// Radix-2 iterative UMUL/SMUL/UDIV/SDIV unit (plain and cc forms) with a
// start/busy/done handshake, high product half / remainder on y_out, own icc flags.
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input logic         clk,
  input logic         reset,
  alu_muldiv_if.slave bus
);

   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
   localparam int CW = $clog2(WIDTH);

   state_t             state;
   logic [CW-1:0]      count;
   logic [2*WIDTH-1:0] acc;      // mul: {partial product, multiplier}; div: {remainder, quotient}
   logic [WIDTH-1:0]   dvsr;     // multiplicand or divisor magnitude
   logic               is_div, is_cc, is_sgn;
   logic               neg_lo, neg_hi;

   logic               busy_r, done_r, n_r, z_r, v_r, c_r, div_zero_r, illegal_r;
   logic [WIDTH-1:0]   out_r, y_r;

   // Request decode: legal codes follow the pattern 0 cc 1 div 1 sgn.
   logic               op_legal, op_cc, op_div, op_sgn, a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;

   // Iteration and write-back datapath.
   logic [WIDTH:0]     mul_sum, div_diff;
   logic [2*WIDTH-1:0] acc_step, prod;
   logic [WIDTH-1:0]   quot, rem, res_lo, res_hi;
   logic               ovf;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      op_legal = 1'b0;
      op_legal = (bus.op3[5] == 1'b0) && bus.op3[3] && bus.op3[1];
      op_cc    = bus.op3[4];
      op_div   = bus.op3[2];
      op_sgn   = bus.op3[0];
      a_neg    = op_sgn & bus.ain[WIDTH-1];
      b_neg    = op_sgn & bus.bin[WIDTH-1];
      a_mag    = a_neg ? -bus.ain : bus.ain;
      b_mag    = b_neg ? -bus.bin : bus.bin;
   end

   always_comb begin
      acc_step = acc;
      mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, dvsr};
      div_diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, dvsr};
      if (is_div) begin
         // Restoring step: a negative trial difference keeps the shifted remainder.
         if (div_diff[WIDTH])
            acc_step = {acc[2*WIDTH-2:0], 1'b0};
         else
            acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
         if (acc[0])
            acc_step = {mul_sum, acc[WIDTH-1:1]};
         else
            acc_step = {1'b0, acc[2*WIDTH-1:1]};
      end
   end

   always_comb begin
      prod   = neg_lo ? -acc : acc;
      quot   = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      rem    = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      // Only most-negative / -1 yields a positive signed quotient of 2^(WIDTH-1).
      ovf    = is_div & is_sgn & ~neg_lo & acc[WIDTH-1];
      res_lo = prod[WIDTH-1:0];
      res_hi = prod[2*WIDTH-1:WIDTH];
      if (is_div) begin
         res_lo = ovf ? {1'b0, {(WIDTH-1){1'b1}}} : quot;
         res_hi = ovf ? '0 : rem;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         count      <= '0;
         acc        <= '0;
         dvsr       <= '0;
         is_div     <= 1'b0;
         is_cc      <= 1'b0;
         is_sgn     <= 1'b0;
         neg_lo     <= 1'b0;
         neg_hi     <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         out_r      <= '0;
         y_r        <= '0;
         n_r        <= 1'b0;
         z_r        <= 1'b0;
         v_r        <= 1'b0;
         c_r        <= 1'b0;
         div_zero_r <= 1'b0;
         illegal_r  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done_r <= 1'b0;
               if (bus.start) begin
                  busy_r     <= 1'b1;
                  div_zero_r <= 1'b0;
                  illegal_r  <= 1'b0;
                  if (!op_legal) begin
                     illegal_r <= 1'b1;
                     done_r    <= 1'b1;
                     state     <= DONE;
                  end else if (op_div && (bus.bin == '0)) begin
                     div_zero_r <= 1'b1;
                     out_r      <= '1;
                     y_r        <= bus.ain;
                     done_r     <= 1'b1;
                     state      <= DONE;
                  end else begin
                     is_div <= op_div;
                     is_cc  <= op_cc;
                     is_sgn <= op_sgn;
                     neg_lo <= a_neg ^ b_neg;
                     neg_hi <= a_neg;
                     dvsr   <= op_div ? b_mag : a_mag;
                     acc    <= {{WIDTH{1'b0}}, (op_div ? a_mag : b_mag)};
                     count  <= CW'(WIDTH - 1);
                     state  <= RUN;
                  end
               end
            end
            RUN: begin
               acc   <= acc_step;
               count <= count - CW'(1);
               if (count == '0)
                  state <= FIX;
            end
            FIX: begin
               out_r <= res_lo;
               y_r   <= res_hi;
               if (is_cc) begin
                  n_r <= res_lo[WIDTH-1];
                  z_r <= (res_lo == '0);
                  v_r <= ovf;
                  c_r <= 1'b0;
               end
               done_r <= 1'b1;
               state  <= DONE;
            end
            DONE: begin
               done_r <= 1'b0;
               busy_r <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy     = busy_r;
   assign bus.done     = done_r;
   assign bus.out      = out_r;
   assign bus.y_out    = y_r;
   assign bus.n        = n_r;
   assign bus.z        = z_r;
   assign bus.v        = v_r;
   assign bus.c        = c_r;
   assign bus.div_zero = div_zero_r;
   assign bus.illegal  = illegal_r;

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: directed vectors push expected results,
// a monitor pops and compares on every done pulse.
module tb_alu_muldiv;

   localparam int W = 32;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   alu_muldiv_if #(.WIDTH(W)) bus();
   alu_muldiv #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

   typedef struct {
      string        name;
      logic [W-1:0] out;
      logic [W-1:0] y;
      logic [3:0]   nzvc;
      logic         dz;
      logic         il;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   done_seen = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h expected=%h", name, got, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset && bus.done) begin
            done_seen++;
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_done out=%h y_out=%h", bus.out, bus.y_out);
            end else begin
               e = sb.pop_front();
               check({e.name, ".out"},   64'(bus.out),   64'(e.out));
               check({e.name, ".y_out"}, 64'(bus.y_out), 64'(e.y));
               check({e.name, ".nzvc"},  64'({bus.n, bus.z, bus.v, bus.c}), 64'(e.nzvc));
               check({e.name, ".dz_il"}, 64'({bus.div_zero, bus.illegal}), 64'({e.dz, e.il}));
            end
         end
      end
   end

   task automatic run_op(input string name, input logic [5:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eo, input logic [W-1:0] ey,
                         input logic [3:0] enzvc, input logic edz, input logic eil,
                         input int exp_cyc, input int hold);
      exp_t e;
      int   cyc;
      bit   busy_ok;
      bit   got;
      e.name = name; e.out = eo; e.y = ey; e.nzvc = enzvc; e.dz = edz; e.il = eil;
      sb.push_back(e);
      cyc = 0; busy_ok = 1'b1; got = 1'b0;
      @(negedge clk);
      bus.op3   = op;
      bus.ain   = a;
      bus.bin   = b;
      bus.start = 1'b1;
      for (int i = 0; i < 100 && !got; i++) begin
         @(posedge clk);
         #1;
         cyc++;
         if (cyc >= hold) bus.start = 1'b0;
         if (bus.done) got = 1'b1;
         if (!bus.busy) busy_ok = 1'b0;
      end
      bus.start = 1'b0;
      if (!got) begin
         total++;
         bad++;
         $display("FAIL %s.timeout no done within 100 cycles", name);
      end else begin
         check({name, ".latency"}, 64'(cyc), 64'(exp_cyc));
         check({name, ".busy"},    64'(busy_ok), 64'(1));
      end
      for (int i = 0; i < 5 && bus.busy; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen0;
      bus.start = 1'b0;
      bus.op3   = '0;
      bus.ain   = '0;
      bus.bin   = '0;
      #1;
      check("reset.data", 64'({bus.out, bus.y_out}), 64'(0));
      check("reset.ctl",  64'({bus.busy, bus.done, bus.n, bus.z, bus.v, bus.c, bus.div_zero, bus.illegal}), 64'(0));
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      //      name         op3        ain           bin           out           y_out         nzvc     dz    il   cyc hold
      run_op("umulcc",     6'b011010, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFE, 32'h1,        4'b1000, 1'b0, 1'b0, 34, 1);
      run_op("smul",       6'b001011, 32'hFFFFFFFD, 32'h5,        32'hFFFFFFF1, 32'hFFFFFFFF, 4'b1000, 1'b0, 1'b0, 34, 1);
      run_op("sdivcc",     6'b011111, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 32'hFFFFFFFF, 4'b1000, 1'b0, 1'b0, 34, 1);
      run_op("sdivcc_ovf", 6'b011111, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h0,        4'b0010, 1'b0, 1'b0, 34, 1);
      run_op("udivcc",     6'b011110, 32'd10,       32'd5,        32'd2,        32'h0,        4'b0000, 1'b0, 1'b0, 34, 1);
      run_op("udiv_zero",  6'b001110, 32'h1234,     32'h0,        32'hFFFFFFFF, 32'h1234,     4'b0000, 1'b1, 1'b0, 1,  1);
      run_op("illegal",    6'b000000, 32'h55,       32'h66,       32'hFFFFFFFF, 32'h1234,     4'b0000, 1'b0, 1'b1, 1,  1);
      seen0 = done_seen;
      run_op("umul_held",  6'b001010, 32'd3,        32'd4,        32'd12,       32'h0,        4'b0000, 1'b0, 1'b0, 34, 10);
      repeat (40) @(posedge clk);
      check("held_start.done_count", 64'(done_seen - seen0), 64'(1));

      // Abort an SMUL ten cycles in with an asynchronous reset.
      @(negedge clk);
      bus.op3 = 6'b001011; bus.ain = 32'hFFFFFFFD; bus.bin = 32'd5; bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (9) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      check("abort.data", 64'({bus.out, bus.y_out}), 64'(0));
      check("abort.ctl",  64'({bus.busy, bus.done, bus.n, bus.z, bus.v, bus.c, bus.div_zero, bus.illegal}), 64'(0));
      seen0 = done_seen;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      repeat (40) @(posedge clk);
      check("abort.no_done", 64'(done_seen - seen0), 64'(0));

      run_op("umul_after", 6'b001010, 32'd6,        32'd7,        32'd42,       32'h0,        4'b0000, 1'b0, 1'b0, 34, 1);
      repeat (5) @(posedge clk);
      check("scoreboard.empty", 64'(sb.size()), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
